// File: rtl/em4100_pkg.sv
// EM4100 frame constants and pure helpers shared by the encoder and decoder.
// Frame vectors keep the first transmitted bit in bit [FRAME_BITS-1].
package em4100_pkg;

  localparam int unsigned FRAME_BITS  = 64;
  localparam int unsigned HEADER_BITS = 9;
  localparam int unsigned ROWS        = 10;
  localparam int unsigned ROW_DATA    = 4;
  localparam int unsigned DATA_W      = 40;
  localparam int unsigned HB_BITS     = 2 * FRAME_BITS;

  typedef logic [FRAME_BITS-1:0] frame_t;
  typedef logic [DATA_W-1:0]     payload_t;

  // Even parity over every 5-bit row and over each data column with its column bit.
  function automatic logic em4100_parity_ok(input frame_t bits);
    logic                ok;
    logic [ROW_DATA-1:0] col;
    ok  = 1'b1;
    col = bits[4:1];
    for (int r = 0; r < int'(ROWS); r++) begin
      ok  = ok & ~(^bits[54-5*r -: 5]);
      col = col ^ bits[54-5*r -: 4];
    end
    return ok & (col == '0);
  endfunction

  // Row data nibbles in transmit order, first data bit lands in the MSB.
  function automatic payload_t em4100_extract(input frame_t bits);
    payload_t p;
    p = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      p[39-4*r -: 4] = bits[54-5*r -: 4];
    end
    return p;
  endfunction

endpackage

// File: rtl/em4100_half_bit_sampler.sv
// Synchronises the Manchester line and strobes once per half-bit at mid-period,
// re-phasing on every line edge and free-running through long runs.
module em4100_half_bit_sampler #(
  parameter int unsigned HALF_BIT_CYCLES = 32,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic d_i,
  output logic strobe_o,
  output logic sample_o
);

  localparam int unsigned CNT_W = $clog2(HALF_BIT_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ds_prev_q, ds_prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   strobe_q, strobe_d;
  logic                   edge_c;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], d_i};
    ds_prev_d = sync_q[SYNC_STAGES-1];
    edge_c    = sync_q[SYNC_STAGES-1] ^ ds_prev_q;
    cnt_d     = cnt_q + CNT_W'(1);
    if (!en_i || edge_c || (cnt_q == CNT_W'(HALF_BIT_CYCLES - 1))) begin
      cnt_d = '0;
    end
    // Registered so strobe_o is high exactly while cnt_q sits at mid half-bit.
    strobe_d = en_i && (cnt_d == CNT_W'(HALF_BIT_CYCLES / 2));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= '0;
      ds_prev_q <= 1'b0;
      cnt_q     <= '0;
      strobe_q  <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      ds_prev_q <= ds_prev_d;
      cnt_q     <= cnt_d;
      strobe_q  <= strobe_d;
    end
  end

  assign strobe_o = strobe_q;
  assign sample_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/em4100_rx.sv
// EM4100 receiver: half-bit shift register, sliding frame alignment and checks,
// registered payload plus one-cycle valid / frame_err strobes.
module em4100_rx
  import em4100_pkg::*;
#(
  parameter int unsigned HALF_BIT_CYCLES = 32,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              d,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_err
);

  localparam logic [7:0] HB_FULL = 8'(HB_BITS);

  logic               strobe, sample;
  logic [HB_BITS-1:0] hb_q, hb_d;
  logic [7:0]         hb_cnt_q, hb_cnt_d;
  logic               chk_q, chk_d;
  payload_t           data_q, data_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  frame_t             frame_c;
  logic               legal_c, aligned_c;

  em4100_half_bit_sampler #(
    .HALF_BIT_CYCLES(HALF_BIT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_sampler (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en),
    .d_i     (d),
    .strobe_o(strobe),
    .sample_o(sample)
  );

  // First half of each pair is the bit value; the second half must differ.
  always_comb begin
    frame_c = '0;
    legal_c = 1'b1;
    for (int k = 0; k < int'(FRAME_BITS); k++) begin
      frame_c[63-k] = hb_q[127-2*k];
      legal_c       = legal_c & (hb_q[127-2*k] ^ hb_q[126-2*k]);
    end
    aligned_c = chk_q && (hb_cnt_q == HB_FULL) && legal_c &&
                (&frame_c[FRAME_BITS-1 -: HEADER_BITS]) && !frame_c[0];
  end

  always_comb begin
    hb_d     = hb_q;
    hb_cnt_d = hb_cnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    chk_d    = en && strobe;
    if (!en) begin
      hb_cnt_d = '0;
    end else begin
      if (strobe) begin
        hb_d     = {hb_q[HB_BITS-2:0], sample};
        hb_cnt_d = (hb_cnt_q == HB_FULL) ? HB_FULL : hb_cnt_q + 8'd1;
      end
      // Evaluated only the cycle after a shift, so each window yields at most one pulse.
      if (aligned_c) begin
        if (em4100_parity_ok(frame_c)) begin
          data_d   = em4100_extract(frame_c);
          valid_d  = 1'b1;
          hb_cnt_d = '0;
        end else begin
          ferr_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hb_q     <= '0;
      hb_cnt_q <= '0;
      chk_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      hb_q     <= hb_d;
      hb_cnt_q <= hb_cnt_d;
      chk_q    <= chk_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_em4100_rx.sv
// Bench for em4100_rx: behavioural EM4100 encoder drives the line; results are
// checked against table constants and a half-bit-level sliding-window model.
module tb_em4100_rx;

  localparam int unsigned H = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        d = 1'b0;
  logic [39:0] data;
  logic        valid, frame_err;

  always #5 clk = ~clk;

  em4100_rx #(.HALF_BIT_CYCLES(H), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d),
    .data(data), .valid(valid), .frame_err(frame_err)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  int unsigned cyc = 0;
  int          vcnt = 0, ecnt = 0, viol = 0;
  logic        prev_pulse = 1'b0;
  int unsigned vcyc[$];
  logic [63:0] frames_q[$];
  logic [39:0] cur_data;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vcnt <= vcnt + 1;
      vcyc.push_back(cyc);
    end
    if (frame_err) ecnt <= ecnt + 1;
    if ((valid && frame_err) || ((valid || frame_err) && prev_pulse)) viol <= viol + 1;
    prev_pulse <= valid | frame_err;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // EM4100 transmitter model; returned vector holds bit k at [63-k].
  function automatic logic [63:0] encode(input logic [39:0] p);
    bit          b[64];
    bit          cp[4];
    bit          rp, x;
    int          idx;
    logic [63:0] f;
    idx = 0;
    cp  = '{0, 0, 0, 0};
    for (int i = 0; i < 9; i++) b[idx++] = 1'b1;
    for (int r = 0; r < 10; r++) begin
      rp = 1'b0;
      for (int j = 0; j < 4; j++) begin
        x = p[39-4*r-j];
        b[idx++] = x;
        rp ^= x;
        cp[j] ^= x;
      end
      b[idx++] = rp;
    end
    for (int j = 0; j < 4; j++) b[idx++] = cp[j];
    b[63] = 1'b0;
    for (int k = 0; k < 64; k++) f[63-k] = b[k];
    return f;
  endfunction

  // Every 128-half-bit window of the stream judged by the frame rules.
  task automatic model_stream(output int ev_v, output int ev_e, inout logic [39:0] md);
    int  n, last, base;
    bit  hs[];
    bit  b[64];
    bit  legal, hdr, par, s;
    n = 128 * frames_q.size();
    hs = new[n];
    for (int f = 0; f < frames_q.size(); f++)
      for (int k = 0; k < 64; k++) begin
        hs[128*f + 2*k]     = frames_q[f][63-k];
        hs[128*f + 2*k + 1] = ~frames_q[f][63-k];
      end
    ev_v = 0; ev_e = 0; last = -1;
    for (int p = 127; p < n; p++) begin
      if (p - last < 128) continue;
      base = p - 127;
      legal = 1'b1;
      for (int k = 0; k < 64; k++) begin
        b[k] = hs[base + 2*k];
        if (hs[base + 2*k] == hs[base + 2*k + 1]) legal = 1'b0;
      end
      hdr = 1'b1;
      for (int k = 0; k < 9; k++) hdr &= b[k];
      par = 1'b1;
      for (int r = 0; r < 10; r++) begin
        s = 1'b0;
        for (int j = 0; j < 5; j++) s ^= b[9+5*r+j];
        if (s) par = 1'b0;
      end
      for (int c = 0; c < 4; c++) begin
        s = b[59+c];
        for (int r = 0; r < 10; r++) s ^= b[9+5*r+c];
        if (s) par = 1'b0;
      end
      if (legal && hdr && !b[63]) begin
        if (par) begin
          ev_v++;
          last = p;
          for (int r = 0; r < 10; r++)
            for (int j = 0; j < 4; j++) md[39-4*r-j] = b[9+5*r+j];
        end else begin
          ev_e++;
        end
      end
    end
  endtask

  task automatic drive_stream(input bit jit);
    int jc, jn, dur;
    bit lvl;
    jc = 0;
    foreach (frames_q[f])
      for (int k = 0; k < 128; k++) begin
        lvl = frames_q[f][63-k/2] ^ bit'(k % 2);
        jn  = jit ? int'($urandom_range(6)) - 3 : 0;
        dur = int'(H) + jn - jc;
        jc  = jn;
        d   = lvl;
        repeat (dur) @(negedge clk);
      end
    d = 1'b0;
    repeat (8*H) @(negedge clk);
  endtask

  typedef struct {
    logic [39:0] payload;
    int          n_good;
    int          n_bad;
    int          flip_k;
    bit          jit;
    int          exp_v;
    int          exp_e;
    logic [39:0] exp_data;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int          v0, e0, ev_v, ev_e;
    logic [39:0] pl, md, xp, yp;
    logic [63:0] bad;

    tbl[0] = '{40'hFFFFF00000, 2, 0, 0, 1'b0, 2, 0, 40'hFFFFF00000};
    tbl[1] = '{40'hFFFFF00000, 0, 1, 9, 1'b0, 0, 1, 40'hFFFFF00000};
    tbl[2] = '{40'h0123456789, 2, 0, 0, 1'b1, 2, 0, 40'h0123456789};
    tbl[3] = '{40'h0000000000, 1, 0, 0, 1'b0, 1, 0, 40'h0000000000};

    repeat (5) @(negedge clk);
    check("reset_data", 64'(data), 64'h0);
    check("reset_valid", 64'(valid), 64'h0);
    check("reset_frame_err", 64'(frame_err), 64'h0);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (8*H) @(negedge clk);
    cur_data = '0;

    foreach (tbl[i]) begin
      frames_q.delete();
      bad = encode(tbl[i].payload);
      bad[63-tbl[i].flip_k] = ~bad[63-tbl[i].flip_k];
      for (int g = 0; g < tbl[i].n_good; g++) frames_q.push_back(encode(tbl[i].payload));
      for (int g = 0; g < tbl[i].n_bad; g++) frames_q.push_back(bad);
      v0 = vcnt; e0 = ecnt; vcyc.delete();
      drive_stream(tbl[i].jit);
      check($sformatf("tbl%0d_valid_count", i), 64'(vcnt - v0), 64'(tbl[i].exp_v));
      check($sformatf("tbl%0d_err_count", i), 64'(ecnt - e0), 64'(tbl[i].exp_e));
      check($sformatf("tbl%0d_data", i), 64'(data), 64'(tbl[i].exp_data));
      if (i == 0 && vcyc.size() >= 2)
        check("tbl0_valid_period", 64'(vcyc[1] - vcyc[0]), 64'(128*H));
      cur_data = tbl[i].exp_data;
    end

    for (int it = 0; it < 2; it++) begin
      pl = {8'($urandom), 32'($urandom)};
      bad = encode(pl);
      bad[63-(9+int'($urandom_range(53)))] ^= 1'b1;
      frames_q.delete();
      frames_q.push_back(encode(pl));
      if ($urandom_range(1) == 1) frames_q.push_back(bad);
      md = cur_data;
      model_stream(ev_v, ev_e, md);
      v0 = vcnt; e0 = ecnt;
      drive_stream(1'b0);
      check($sformatf("rand%0d_valid_count", it), 64'(vcnt - v0), 64'(ev_v));
      check($sformatf("rand%0d_err_count", it), 64'(ecnt - e0), 64'(ev_e));
      check($sformatf("rand%0d_data", it), 64'(data), 64'(md));
      cur_data = md;
    end

    // Reset at half-bit 70 of the first frame; only the second frame may decode.
    pl = 40'hDEADBEEF12;
    frames_q.delete();
    frames_q.push_back(encode(pl));
    frames_q.push_back(encode(pl));
    v0 = vcnt; e0 = ecnt;
    fork
      drive_stream(1'b0);
      begin
        repeat (70*H + 8) @(negedge clk);
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_data_cleared", 64'(data), 64'h0);
        repeat (58*H) @(negedge clk);
        check("rst_mid_no_pulse", 64'((vcnt - v0) + (ecnt - e0)), 64'h0);
      end
    join
    check("rst_mid_valid_count", 64'(vcnt - v0), 64'd1);
    check("rst_mid_err_count", 64'(ecnt - e0), 64'd0);
    check("rst_mid_data", 64'(data), 64'(pl));

    // en low for 2000 cycles across the second frame.
    xp = 40'h13579BDF02;
    yp = 40'hA5C396E10F;
    frames_q.delete();
    frames_q.push_back(encode(xp));
    frames_q.push_back(encode(yp));
    frames_q.push_back(encode(yp));
    v0 = vcnt; e0 = ecnt;
    fork
      drive_stream(1'b0);
      begin
        int hv, he;
        repeat (150*H) @(negedge clk);
        en = 1'b0;
        hv = vcnt; he = ecnt;
        repeat (2000) @(negedge clk);
        check("en_low_no_pulse", 64'((vcnt - hv) + (ecnt - he)), 64'h0);
        check("en_low_data_held", 64'(data), 64'(xp));
        en = 1'b1;
      end
    join
    check("en_valid_count", 64'(vcnt - v0), 64'd2);
    check("en_data", 64'(data), 64'(yp));

    // Constant-high line never forms legal Manchester pairs.
    v0 = vcnt; e0 = ecnt;
    d = 1'b1;
    repeat (10000) @(negedge clk);
    d = 1'b0;
    repeat (8*H) @(negedge clk);
    check("const_valid_count", 64'(vcnt - v0), 64'h0);
    check("const_err_count", 64'(ecnt - e0), 64'h0);
    check("const_data_held", 64'(data), 64'(yp));

    check("pulse_exclusive", 64'(viol), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/em4100_rx.md
Name: em4100_rx

Overview:
- EM4100 receiver/decoder.
- Directly downstream of the EM4100 transmitter: consumes its serial Manchester line `q`.
- Recovers half-bit timing, aligns to the 64-bit EM4100 frame, checks Manchester validity, header, row/column parity and stop bit.
- Presents the 40-bit payload with a one-cycle valid strobe. Used as the loopback checker and as the reader-side front end.

Parameters:
- HALF_BIT_CYCLES, 32, clk cycles per Manchester half-bit (RF/64 bit period). Legal range ≥4, even.
- SYNC_STAGES, 2, input synchroniser depth (≥2).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  receive enable; low holds the receiver idle.
- d  in  1  serial Manchester line (transmitter `q`); asynchronous to frame timing.
- data  out  40  last correctly decoded payload, MSB = first transmitted data bit.
- valid  out  1  one-cycle pulse: `data` updated with a good frame.
- frame_err  out  1  one-cycle pulse: aligned frame with bad parity.

Behaviour:
- Reset (rst_n low at a clk edge):
  - synchroniser flops, timer, 128-bit half-bit shift register hb and fill count hb_cnt go to 0.
  - data = 0, valid = 0, frame_err = 0.
  - Mid-frame reset discards partial frames; a full new frame is required afterwards.
- Input synchroniser: SYNC_STAGES flops on d, giving ds.
- Edge detection: ds != previous ds.
- Half-bit timer cnt, range 0..HALF_BIT_CYCLES-1:
  - On an edge, cnt ← 0.
  - Else if cnt == HALF_BIT_CYCLES-1, cnt ← 0.
  - Else cnt ← cnt+1.
  - Strobe when cnt == HALF_BIT_CYCLES/2, so each half-bit is sampled mid-period. Edges resynchronise phase; long runs are handled by wrap.
- On strobe:
  - hb ← {hb[126:0], ds}.
  - hb_cnt ← min(hb_cnt+1, 128).
- Manchester convention: bit value = first-half level. 1 = high-then-low, 0 = low-then-high.
- Frame candidate, evaluated combinationally from hb when hb_cnt == 128, oldest half-bit at hb[127]:
  - Bit k (k = 0 first transmitted … 63) = hb[127-2k].
  - Manchester-legal only if hb[127-2k] != hb[126-2k].
- Frame layout:
  - Bits 0..8: header, all 1.
  - Bits 9..58: 10 rows of 4 data bits + 1 even row parity.
  - Bits 59..62: 4 even column parity bits over the 10 rows.
  - Bit 63: stop bit, 0.
- Result is registered on the clk edge following the strobe that captured the final half-bit, i.e. 1 cycle latency after strobe:
  - All pairs legal, header ok, stop ok, all parity ok → data ← 40 data bits in transmit order, valid = 1 for one cycle, hb_cnt ← 0 (no re-match on the same half-bits).
  - Pairs legal, header ok, stop ok, any parity wrong → frame_err = 1 for one cycle. data holds. hb_cnt is not cleared (sliding search continues).
  - Anything else → no pulse.
- valid and frame_err are mutually exclusive and never high two consecutive cycles.
- en low:
  - cnt, hb_cnt forced to 0; no strobes; valid and frame_err forced 0 that cycle, even if a match completes in the same cycle.
  - data holds. Synchroniser keeps running.
- Repeated identical frames from the transmitter produce one valid per frame, every 128·HALF_BIT_CYCLES cycles.
- Widths: cnt is $clog2(HALF_BIT_CYCLES) bits; hb_cnt is 8 bits saturating at 128.

Decomposition:
- Package em4100_pkg:
  - FRAME_BITS=64, HEADER_BITS=9, ROWS=10, ROW_DATA=4, DATA_W=40.
  - Pure functions `em4100_parity_ok(bits[63:0])` and `em4100_extract(bits[63:0])→[39:0]`.
  - Shared with the transmitter so encode and decode agree.
- Sub-module em4100_half_bit_sampler: synchroniser + edge detect + timer, outputs (strobe, sample).
- Top: hb shift register, frame check, output registers.

Test Plan:
- Transmitter → receiver loopback, HALF_BIT_CYCLES=32, payload 40'hFFFFF00000 (row parity all 0, column parity 4'b1111) → valid once per 4096 cycles after the first full frame, data = 40'hFFFFF00000, frame_err never.
- Same stream with one data bit inverted (payload bit 39) → frame_err pulse at the frame end, no valid, data keeps its previous value.
- Payload 40'h0123456789 with ±3-cycle jitter on every edge of d → valid, data = 40'h0123456789.
- Reset asserted at half-bit 70 of a frame, released 10 cycles later → no pulse for the rest of that frame, valid on the next complete frame.
- en low for 2000 cycles mid-stream → no valid/frame_err while low, data held; first valid comes on the first complete frame after en rises.
- d held constant 1 for 10000 cycles → no valid, no frame_err (Manchester-illegal pairs).
